// File: rtl/cmac_pkg.sv
// ---------------------------------------------------------------------------
// cmac_pkg
//
// Shared definitions for the sequential complex multiply-accumulate engine
// (cmac_seq and its controller cmac_ctrl):
//   - state_t   : controller FSM states (IDLE, RUN)
//   - PH_*      : phase encoding of the four real products of one term
//   - sat_res_t : {ovf, sum} result of one accumulate step
//   - sat_add() : one accumulate step with overflow detection, wrapping or
//                 saturating to a signed acc_w-bit range
//
// Configuration macro: CMAC_SAT_EN
//   undefined : an out-of-range sum wraps (two's complement) to acc_w bits
//   defined   : an out-of-range sum clamps to the nearest signed limit
// In both builds the ovf flag of the result is set when the exact sum does
// not fit in acc_w signed bits.
// ---------------------------------------------------------------------------
package cmac_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Phase p = step & 3 selects which real product is formed and where it goes.
    localparam logic [1:0] PH_RR = 2'd0;  // re += xr*yr
    localparam logic [1:0] PH_II = 2'd1;  // re -= xi*yi   (conj: re += xi*yi)
    localparam logic [1:0] PH_RI = 2'd2;  // im += xr*yi   (conj: im -= xr*yi)
    localparam logic [1:0] PH_IR = 2'd3;  // im += xi*yr

    // Working width of sat_add. Operands are sign-extended to this width so
    // the exact sum of an acc_w-bit accumulator and a product can never wrap
    // here; acc_w must therefore stay well below SA_W (any acc_w <= 62).
    localparam int SA_W = 64;

    typedef struct packed {
        logic                   ovf;
        logic signed [SA_W-1:0] sum;
    } sat_res_t;

    // One accumulate step: a + b, range-checked against signed acc_w bits.
    // The returned sum is already reduced to the acc_w range (wrapped or
    // clamped) and sign-extended back to SA_W bits.
    function automatic sat_res_t sat_add(
        input logic signed [SA_W-1:0] a,
        input logic signed [SA_W-1:0] b,
        input int                     acc_w
    );
        logic signed [SA_W-1:0] s;
        logic signed [SA_W-1:0] max_v;
        logic signed [SA_W-1:0] min_v;
        sat_res_t               r;
        s     = a + b;
        max_v = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        r.ovf = (s > max_v) || (s < min_v);
`ifdef CMAC_SAT_EN
        if (s > max_v) begin
            r.sum = max_v;
        end else if (s < min_v) begin
            r.sum = min_v;
        end else begin
            r.sum = s;
        end
`else
        // Keep the low acc_w bits and re-extend their sign bit.
        r.sum = (s <<< (SA_W - acc_w)) >>> (SA_W - acc_w);
`endif
        return r;
    endfunction

endpackage

// File: rtl/cmac_ctrl.sv
// ---------------------------------------------------------------------------
// cmac_ctrl
//
// Controller for cmac_seq: two-state FSM (IDLE/RUN), the 0..4N-1 step
// counter and the done pulse. The datapath takes all its strobes from here.
//
// Ports:
//   i_clk      in   clock, rising edge
//   i_rst      in   synchronous active-high reset
//   i_start    in   start request; only acted on in IDLE
//   o_state    out  current FSM state (debug / checker visibility)
//   o_step     out  current step s while in RUN (0 in IDLE)
//   o_load     out  start accepted this cycle: latch operands, load accumulators
//   o_step_en  out  a multiply-accumulate step executes this cycle (RUN)
//   o_last     out  this is step 4N-1; result register loads at this edge
//   o_done     out  registered one-cycle pulse, high in the cycle after o_last
//
// Handshake: a start is accepted at the rising edge where i_start=1 and the
// FSM is IDLE (ready). The FSM then spends exactly 4N cycles in RUN, one step
// per cycle, and returns to IDLE with done=1 for one cycle. Because done
// coincides with IDLE, a start in the done cycle is accepted immediately.
// Starts seen while in RUN are dropped, nothing is queued.
// ---------------------------------------------------------------------------
import cmac_pkg::*;

module cmac_ctrl #(
    parameter int N      = 4,
    parameter int STEP_W = $clog2(4 * N)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output state_t            o_state,
    output logic [STEP_W-1:0] o_step,
    output logic              o_load,
    output logic              o_step_en,
    output logic              o_last,
    output logic              o_done
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(4 * N - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [STEP_W-1:0] r_step;
    logic [STEP_W-1:0] w_next_step;
    logic              r_done;

    always_comb begin
        w_next_state = r_state;
        w_next_step  = r_step;
        o_load       = 1'b0;
        o_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_next_state = RUN;
                    w_next_step  = '0;
                    o_load       = 1'b1;
                end
            end
            RUN: begin
                if (r_step == LAST_STEP) begin
                    w_next_state = IDLE;
                    w_next_step  = '0;
                    o_last       = 1'b1;
                end else begin
                    w_next_step = r_step + STEP_W'(1);
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_step  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_step  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_step  <= w_next_step;
            // Reset clears this too, so an aborted run never pulses done.
            r_done  <= o_last;
        end
    end

    assign o_state   = r_state;
    assign o_step    = r_step;
    assign o_step_en = (r_state == RUN);
    assign o_done    = r_done;

endmodule

// File: rtl/cmac_seq.sv
// ---------------------------------------------------------------------------
// cmac_seq
//
// Sequential complex dot-product engine:
//   res = sum_{k=0..N-1} X[k]*Y[k]        (conj=0)
//   res = sum_{k=0..N-1} X[k]*conj(Y[k])  (conj=1)
// One signed W x W multiplier is time-shared over four phases per term, so a
// run takes 4N cycles in RUN; start->ready latency is 4N+1 cycles.
// With keep=1 a run continues from the previous result (run chaining).
//
// Parameters:
//   W      component width (signed), N terms per run, ACC_W accumulator width
//          per half (ACC_W >= 2W+1).
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset; also aborts a run
//   start  in   begin a run; sampled only while ready=1
//   conj   in   0: X*Y, 1: X*conj(Y); latched at start
//   keep   in   0: clear accumulators and ovf at start, 1: continue from res
//   x_vec  in   N*2W; term k at [2W*k +: 2W], real = upper W, imag = lower W
//   y_vec  in   same packing as x_vec
//   res    out  {re, im}, ACC_W each, registered; updated when done pulses
//   ready  out  high in IDLE; res valid
//   done   out  one-cycle pulse when a run completes
//   ovf    out  sticky accumulator overflow flag
//
// Configuration macro: CMAC_SAT_EN (saturating instead of wrapping steps;
// see cmac_pkg::sat_add).
//
// Handshake: start is taken at a rising edge with ready=1; operands, conj and
// keep are captured at that edge and may change afterwards. ready falls for
// 4N cycles and returns together with a one-cycle done pulse and the new
// res. res holds the previous result for the whole run.
// ---------------------------------------------------------------------------
import cmac_pkg::*;

module cmac_seq #(
    parameter int W     = 4,
    parameter int N     = 4,
    parameter int ACC_W = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 conj,
    input  logic                 keep,
    input  logic [N*2*W-1:0]     x_vec,
    input  logic [N*2*W-1:0]     y_vec,
    output logic [2*ACC_W-1:0]   res,
    output logic                 ready,
    output logic                 done,
    output logic                 ovf
);

    localparam int STEP_W = $clog2(4 * N);

    // ---------------- controller ----------------
    state_t            w_state;
    logic [STEP_W-1:0] w_step;
    logic              w_load;
    logic              w_step_en;
    logic              w_last;
    logic              w_done;

    cmac_ctrl #(
        .N      (N),
        .STEP_W (STEP_W)
    ) u_ctrl (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .o_state   (w_state),
        .o_step    (w_step),
        .o_load    (w_load),
        .o_step_en (w_step_en),
        .o_last    (w_last),
        .o_done    (w_done)
    );

    // ---------------- registers ----------------
    logic [N*2*W-1:0]        r_x;
    logic [N*2*W-1:0]        r_y;
    logic                    r_conj;
    logic signed [ACC_W-1:0] r_acc_re;
    logic signed [ACC_W-1:0] r_acc_im;
    logic [2*ACC_W-1:0]      r_res;
    logic                    r_ovf;

    // ---------------- operand select ----------------
    int                      w_term;
    logic [1:0]              w_phase;
    logic signed [W-1:0]     w_xr;
    logic signed [W-1:0]     w_xi;
    logic signed [W-1:0]     w_yr;
    logic signed [W-1:0]     w_yi;

    assign w_phase = w_step[1:0];

    always_comb begin
        w_term = int'(w_step >> 2);
        w_xr   = r_x[2*W*w_term + W +: W];
        w_xi   = r_x[2*W*w_term     +: W];
        w_yr   = r_y[2*W*w_term + W +: W];
        w_yi   = r_y[2*W*w_term     +: W];
    end

    // Per phase: multiplier operands, whether the product is subtracted, and
    // which half (re/im) it accumulates into.
    logic signed [W-1:0]     w_mul_a;
    logic signed [W-1:0]     w_mul_b;
    logic                    w_neg;
    logic                    w_to_im;

    always_comb begin
        w_mul_a = w_xr;
        w_mul_b = w_yr;
        w_neg   = 1'b0;
        w_to_im = 1'b0;
        case (w_phase)
            PH_RR: begin
                w_mul_a = w_xr;
                w_mul_b = w_yr;
            end
            PH_II: begin
                w_mul_a = w_xi;
                w_mul_b = w_yi;
                w_neg   = ~r_conj;
            end
            PH_RI: begin
                w_mul_a = w_xr;
                w_mul_b = w_yi;
                w_neg   = r_conj;
                w_to_im = 1'b1;
            end
            default: begin  // PH_IR
                w_mul_a = w_xi;
                w_mul_b = w_yr;
                w_to_im = 1'b1;
            end
        endcase
    end

    // ---------------- shared multiplier + accumulate ----------------
    logic signed [2*W-1:0]   w_prod;
    logic signed [SA_W-1:0]  w_prod_ext;
    logic signed [SA_W-1:0]  w_addend;
    logic signed [SA_W-1:0]  w_acc_cur;
    sat_res_t                w_sa;
    logic signed [ACC_W-1:0] w_acc_new;
    logic signed [ACC_W-1:0] w_re_next;
    logic signed [ACC_W-1:0] w_im_next;
    logic                    w_unused_hi;

    assign w_prod     = w_mul_a * w_mul_b;
    assign w_prod_ext = {{(SA_W-2*W){w_prod[2*W-1]}}, w_prod};
    // Negation happens after widening, so even the most negative product
    // negates without wrapping.
    assign w_addend   = w_neg ? -w_prod_ext : w_prod_ext;
    assign w_acc_cur  = w_to_im ? {{(SA_W-ACC_W){r_acc_im[ACC_W-1]}}, r_acc_im}
                                : {{(SA_W-ACC_W){r_acc_re[ACC_W-1]}}, r_acc_re};
    assign w_sa       = sat_add(w_acc_cur, w_addend, ACC_W);
    assign w_acc_new  = w_sa.sum[ACC_W-1:0];
    // Upper bits are only the sign extension of w_acc_new.
    assign w_unused_hi = ^w_sa.sum[SA_W-1:ACC_W];

    assign w_re_next = (w_step_en && !w_to_im) ? w_acc_new : r_acc_re;
    assign w_im_next = (w_step_en &&  w_to_im) ? w_acc_new : r_acc_im;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x      <= '0;
            r_y      <= '0;
            r_conj   <= 1'b0;
            r_acc_re <= '0;
            r_acc_im <= '0;
            r_res    <= '0;
            r_ovf    <= 1'b0;
        end else if (w_load) begin
            r_x    <= x_vec;
            r_y    <= y_vec;
            r_conj <= conj;
            if (keep) begin
                r_acc_re <= r_res[2*ACC_W-1:ACC_W];
                r_acc_im <= r_res[ACC_W-1:0];
            end else begin
                r_acc_re <= '0;
                r_acc_im <= '0;
                r_ovf    <= 1'b0;
            end
        end else if (w_step_en) begin
            r_acc_re <= w_re_next;
            r_acc_im <= w_im_next;
            if (w_sa.ovf) begin
                r_ovf <= 1'b1;
            end
            // The final step's sum goes straight into res so the result is
            // visible in the same cycle as the done pulse.
            if (w_last) begin
                r_res <= {w_re_next, w_im_next};
            end
        end
    end

    assign res   = r_res;
    assign ready = (w_state == IDLE);
    assign done  = w_done;
    assign ovf   = r_ovf;

endmodule
